// File: rtl/pipe_control_unit_if.sv
// Control bundle between the Y86-64 stage registers and pipe_control_unit.
// master = pipeline datapath side, slave = hazard/status controller side.
interface pipe_control_unit_if #(
    parameter int CNT_W = 32
);
    logic             run_en;
    logic [3:0]       D_icode;
    logic [3:0]       d_srcA;
    logic [3:0]       d_srcB;
    logic [3:0]       E_icode;
    logic [3:0]       E_dstM;
    logic             e_Cnd;
    logic [3:0]       M_icode;
    logic [3:0]       m_stat;
    logic [3:0]       W_stat;
    logic [3:0]       W_icode;

    logic             F_stall;
    logic             D_stall;
    logic             W_stall;
    logic             D_bubble;
    logic             E_bubble;
    logic             M_bubble;
    logic             W_bubble;
    logic             set_cc;
    logic [3:0]       cpu_stat;
    logic [CNT_W-1:0] cyc_cnt;
    logic [CNT_W-1:0] ret_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] misp_cnt;

    modport master (
        output run_en, D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd,
               M_icode, m_stat, W_stat, W_icode,
        input  F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, W_bubble,
               set_cc, cpu_stat, cyc_cnt, ret_cnt, stall_cnt, misp_cnt
    );

    modport slave (
        input  run_en, D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd,
               M_icode, m_stat, W_stat, W_icode,
        output F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, W_bubble,
               set_cc, cpu_stat, cyc_cnt, ret_cnt, stall_cnt, misp_cnt
    );
endinterface

// File: rtl/pipe_control_unit.sv
// Y86-64 5-stage hazard controller: per-cycle stall/bubble generation, CPU status FSM
// (run/pause/halt/fault) and saturating performance counters.
module pipe_control_unit #(
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    pipe_control_unit_if.slave ctl
);
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] R_NONE   = 4'hF;
    localparam logic [3:0] S_ADR    = 4'h1;
    localparam logic [3:0] S_INS    = 4'h2;
    localparam logic [3:0] S_HLT    = 4'h3;
    localparam logic [3:0] S_AOK    = 4'h4;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_PAUSE,
        ST_HALT,
        ST_FAULT
    } state_t;

    state_t           state;
    logic [3:0]       cpu_stat;
    logic [CNT_W-1:0] cyc_cnt;
    logic [CNT_W-1:0] ret_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] misp_cnt;

    logic load_use;
    logic ret_p;
    logic misp;
    logic m_exc;
    logic w_exc;

    logic f_stall;
    logic d_stall;
    logic w_stall;
    logic d_bubble;
    logic e_bubble;
    logic m_bubble;
    logic w_bubble;
    logic set_cc;

    function automatic logic is_exc(input logic [3:0] s);
        return (s == S_ADR) || (s == S_INS) || (s == S_HLT);
    endfunction

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    assign load_use = ((ctl.E_icode == I_MRMOVQ) || (ctl.E_icode == I_POPQ))
                   && (ctl.E_dstM != R_NONE)
                   && ((ctl.E_dstM == ctl.d_srcA) || (ctl.E_dstM == ctl.d_srcB));
    assign ret_p    = (ctl.D_icode == I_RET) || (ctl.E_icode == I_RET) || (ctl.M_icode == I_RET);
    assign misp     = (ctl.E_icode == I_JXX) && !ctl.e_Cnd;
    assign m_exc    = is_exc(ctl.m_stat);
    assign w_exc    = is_exc(ctl.W_stat);

    always_comb begin
        // NOTE: every output gets a default first so no path through this block infers a latch.
        f_stall  = 1'b0;
        d_stall  = 1'b0;
        w_stall  = 1'b0;
        d_bubble = 1'b0;
        e_bubble = 1'b0;
        m_bubble = 1'b0;
        w_bubble = 1'b0;
        set_cc   = 1'b0;
        if (reset) begin
            // Flush: every downstream register loads a NOP while reset is held.
            d_bubble = 1'b1;
            e_bubble = 1'b1;
            m_bubble = 1'b1;
            w_bubble = 1'b1;
        end else if (state == ST_RUN) begin
            f_stall  = load_use | ret_p;
            d_stall  = load_use;
            d_bubble = misp | (ret_p & !load_use);
            e_bubble = misp | load_use;
            m_bubble = m_exc | w_exc;
            w_stall  = w_exc;
            set_cc   = (ctl.E_icode == I_OPQ) && !m_exc && !w_exc;
        end else begin
            f_stall  = 1'b1;
            d_stall  = 1'b1;
            w_stall  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state     <= ST_RUN;
            cpu_stat  <= S_AOK;
            cyc_cnt   <= '0;
            ret_cnt   <= '0;
            stall_cnt <= '0;
            misp_cnt  <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    cyc_cnt   <= sat_inc(cyc_cnt, 1'b1);
                    ret_cnt   <= sat_inc(ret_cnt, (ctl.W_stat == S_AOK) && (ctl.W_icode != I_NOP) && !w_bubble);
                    stall_cnt <= sat_inc(stall_cnt, f_stall);
                    misp_cnt  <= sat_inc(misp_cnt, misp);
                    // Retirement status outranks a pause request.
                    if (ctl.W_stat == S_HLT) begin
                        state    <= ST_HALT;
                        cpu_stat <= S_HLT;
                    end else if ((ctl.W_stat == S_ADR) || (ctl.W_stat == S_INS)) begin
                        state    <= ST_FAULT;
                        cpu_stat <= ctl.W_stat;
                    end else if (!ctl.run_en) begin
                        state    <= ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (ctl.run_en) begin
                        state <= ST_RUN;
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

    assign ctl.F_stall   = f_stall;
    assign ctl.D_stall   = d_stall;
    assign ctl.W_stall   = w_stall;
    assign ctl.D_bubble  = d_bubble;
    assign ctl.E_bubble  = e_bubble;
    assign ctl.M_bubble  = m_bubble;
    assign ctl.W_bubble  = w_bubble;
    assign ctl.set_cc    = set_cc;
    assign ctl.cpu_stat  = cpu_stat;
    assign ctl.cyc_cnt   = cyc_cnt;
    assign ctl.ret_cnt   = ret_cnt;
    assign ctl.stall_cnt = stall_cnt;
    assign ctl.misp_cnt  = misp_cnt;
endmodule

// File: tb/tb_pipe_control_unit.sv
// Self-checking bench for pipe_control_unit: directed hazard scenarios plus randomized
// traffic compared against a behavioural model of the control rules and status machine.
module tb_pipe_control_unit;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipe_control_unit_if #(.CNT_W(CNT_W)) bus ();

    pipe_control_unit #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .ctl   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model state: status flags, retirement code and unbounded-then-clamped counters.
    bit mdl_halted, mdl_faulted, mdl_paused;
    int mdl_stat;
    int mdl_cyc, mdl_ret, mdl_stall, mdl_misp;

    bit exp_f_stall, exp_d_stall, exp_w_stall;
    bit exp_d_bubble, exp_e_bubble, exp_m_bubble, exp_w_bubble, exp_set_cc;
    bit cur_misp;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit is_exception(input int s);
        return (s >= 1) && (s <= 3);
    endfunction

    function automatic int clamp_inc(input int v);
        return (v + 1 > CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    task automatic mdl_reset();
        mdl_halted  = 0;
        mdl_faulted = 0;
        mdl_paused  = 0;
        mdl_stat    = 4;
        mdl_cyc     = 0;
        mdl_ret     = 0;
        mdl_stall   = 0;
        mdl_misp    = 0;
    endtask

    task automatic compute_expected();
        bit lu, rp, frozen;
        int ei;
        ei = int'(bus.E_icode);
        lu = (ei == 5 || ei == 11) && bus.E_dstM != 4'hF
             && (bus.E_dstM == bus.d_srcA || bus.E_dstM == bus.d_srcB);
        rp = (bus.D_icode == 4'd9) || (bus.E_icode == 4'd9) || (bus.M_icode == 4'd9);
        cur_misp = (ei == 7) && !bus.e_Cnd;
        frozen = mdl_halted || mdl_faulted || mdl_paused;
        {exp_f_stall, exp_d_stall, exp_w_stall} = '0;
        {exp_d_bubble, exp_e_bubble, exp_m_bubble, exp_w_bubble, exp_set_cc} = '0;
        if (reset) begin
            {exp_d_bubble, exp_e_bubble, exp_m_bubble, exp_w_bubble} = 4'b1111;
        end else if (frozen) begin
            {exp_f_stall, exp_d_stall, exp_w_stall} = 3'b111;
        end else begin
            exp_f_stall  = lu || rp;
            exp_d_stall  = lu;
            exp_d_bubble = cur_misp || (rp && !lu);
            exp_e_bubble = cur_misp || lu;
            exp_m_bubble = is_exception(int'(bus.m_stat)) || is_exception(int'(bus.W_stat));
            exp_w_stall  = is_exception(int'(bus.W_stat));
            exp_set_cc   = (ei == 6) && !is_exception(int'(bus.m_stat))
                           && !is_exception(int'(bus.W_stat));
        end
    endtask

    task automatic mdl_advance();
        if (reset) begin
            mdl_reset();
        end else if (mdl_halted || mdl_faulted) begin
            mdl_stat = mdl_stat;
        end else if (mdl_paused) begin
            mdl_paused = !bus.run_en;
        end else begin
            mdl_cyc = clamp_inc(mdl_cyc);
            if (bus.W_stat == 4'd4 && bus.W_icode != 4'd1 && !exp_w_bubble) mdl_ret = clamp_inc(mdl_ret);
            if (exp_f_stall) mdl_stall = clamp_inc(mdl_stall);
            if (cur_misp) mdl_misp = clamp_inc(mdl_misp);
            if (bus.W_stat == 4'd3) begin
                mdl_halted = 1;
                mdl_stat   = 3;
            end else if (bus.W_stat == 4'd1 || bus.W_stat == 4'd2) begin
                mdl_faulted = 1;
                mdl_stat    = int'(bus.W_stat);
            end else if (!bus.run_en) begin
                mdl_paused = 1;
            end
        end
    endtask

    task automatic step(input string tag);
        @(negedge clk);
        compute_expected();
        check({tag, ".F_stall"},   bus.F_stall,   exp_f_stall);
        check({tag, ".D_stall"},   bus.D_stall,   exp_d_stall);
        check({tag, ".W_stall"},   bus.W_stall,   exp_w_stall);
        check({tag, ".D_bubble"},  bus.D_bubble,  exp_d_bubble);
        check({tag, ".E_bubble"},  bus.E_bubble,  exp_e_bubble);
        check({tag, ".M_bubble"},  bus.M_bubble,  exp_m_bubble);
        check({tag, ".W_bubble"},  bus.W_bubble,  exp_w_bubble);
        check({tag, ".set_cc"},    bus.set_cc,    exp_set_cc);
        check({tag, ".cpu_stat"},  bus.cpu_stat,  mdl_stat);
        check({tag, ".cyc_cnt"},   bus.cyc_cnt,   mdl_cyc);
        check({tag, ".ret_cnt"},   bus.ret_cnt,   mdl_ret);
        check({tag, ".stall_cnt"}, bus.stall_cnt, mdl_stall);
        check({tag, ".misp_cnt"},  bus.misp_cnt,  mdl_misp);
        mdl_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus.run_en  = 1'b1;
        bus.D_icode = 4'h1;
        bus.E_icode = 4'h1;
        bus.M_icode = 4'h1;
        bus.W_icode = 4'h1;
        bus.d_srcA  = 4'hF;
        bus.d_srcB  = 4'hF;
        bus.E_dstM  = 4'hF;
        bus.e_Cnd   = 1'b1;
        bus.m_stat  = 4'h4;
        bus.W_stat  = 4'h4;
    endtask

    function automatic logic [3:0] pick_icode();
        logic [3:0] hot [5];
        hot = '{4'h5, 4'hB, 4'h9, 4'h7, 4'h6};
        if ($urandom_range(0, 2) != 0) return hot[$urandom_range(0, 4)];
        return 4'($urandom_range(0, 15));
    endfunction

    function automatic logic [3:0] pick_stat(input bit allow_exc);
        if (allow_exc && $urandom_range(0, 9) == 0) return 4'($urandom_range(1, 3));
        return ($urandom_range(0, 19) == 0) ? 4'h0 : 4'h4;
    endfunction

    task automatic rand_inputs(input bit allow_exc);
        bus.run_en  = ($urandom_range(0, 9) != 0);
        bus.D_icode = pick_icode();
        bus.E_icode = pick_icode();
        bus.M_icode = pick_icode();
        bus.W_icode = 4'($urandom_range(0, 15));
        bus.d_srcA  = 4'($urandom_range(0, 15));
        bus.d_srcB  = 4'($urandom_range(0, 15));
        bus.E_dstM  = ($urandom_range(0, 1) == 0) ? bus.d_srcA : 4'($urandom_range(0, 15));
        bus.e_Cnd   = 1'($urandom_range(0, 1));
        bus.m_stat  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 3)) : 4'h4;
        bus.W_stat  = pick_stat(allow_exc);
    endtask

    initial begin
        reset = 1'b1;
        set_idle();
        mdl_reset();
        @(posedge clk);
        #1;

        // Reset held with hazards pending: flush wins over every hazard rule.
        bus.D_icode = 4'h9;
        bus.E_icode = 4'h7;
        bus.e_Cnd   = 1'b0;
        step("reset0");
        step("reset1");
        reset = 1'b0;
        set_idle();
        step("idle");

        // Load/use on srcA, then load/use together with ret in D.
        bus.E_icode = 4'h5;
        bus.E_dstM  = 4'h3;
        bus.d_srcA  = 4'h3;
        step("loaduse");
        check("loaduse.stall_cnt_after", bus.stall_cnt, 1);
        bus.D_icode = 4'h9;
        step("loaduse_ret");

        // ret walking through D, E and M.
        set_idle();
        bus.D_icode = 4'h9;
        step("ret_D");
        bus.D_icode = 4'h1;
        bus.E_icode = 4'h9;
        step("ret_E");
        bus.E_icode = 4'h1;
        bus.M_icode = 4'h9;
        step("ret_M");

        // Mispredicted jump with ret in D on the same cycle.
        set_idle();
        bus.E_icode = 4'h7;
        bus.e_Cnd   = 1'b0;
        bus.D_icode = 4'h9;
        step("misp_ret");
        check("misp.misp_cnt_after", bus.misp_cnt, 1);
        bus.E_icode = 4'h6;
        bus.D_icode = 4'h1;
        bus.W_icode = 4'h2;
        step("opq_retire");

        for (int i = 0; i < 300; i++) begin
            rand_inputs(1'b0);
            step("rand_run");
        end

        // Pause for four cycles after the RUN->PAUSE edge, then resume.
        set_idle();
        step("pre_pause");
        bus.run_en = 1'b0;
        for (int i = 0; i < 5; i++) step("pause");
        bus.run_en = 1'b1;
        step("resume0");
        step("resume1");

        // Saturation: a long run with ret held in D drives cyc/stall counters to all-ones.
        reset = 1'b1;
        step("sat_reset");
        reset = 1'b0;
        set_idle();
        bus.D_icode = 4'h9;
        for (int i = 0; i < CNT_MAX + 10; i++) step("sat");
        check("sat.cyc_cnt", bus.cyc_cnt, CNT_MAX);
        check("sat.stall_cnt", bus.stall_cnt, CNT_MAX);

        // Halt at W, then frozen under random traffic.
        set_idle();
        bus.W_stat = 4'h3;
        step("halt");
        check("halt.cpu_stat", bus.cpu_stat, 3);
        for (int i = 0; i < 6; i++) begin
            rand_inputs(1'b1);
            step("halted");
        end

        // Reset out of HALT, then a fault latched with its status code.
        reset = 1'b1;
        step("halt_reset");
        reset = 1'b0;
        set_idle();
        step("after_halt");
        check("after_halt.cpu_stat", bus.cpu_stat, 4);
        bus.W_stat = 4'h2;
        step("fault");
        set_idle();
        step("faulted");
        check("fault.cpu_stat", bus.cpu_stat, 2);

        // Random traffic with exceptions and occasional resets.
        for (int i = 0; i < 500; i++) begin
            rand_inputs(1'b1);
            reset = ($urandom_range(0, 24) == 0);
            step("rand_exc");
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
